// File: rtl/bp_io_dev_router.sv
// Single-outstanding I/O command router: decodes addr[23:20] to a local device,
// runs one command/response exchange, and returns data or an error to the requester.
module bp_io_dev_router #(
   parameter int paddr_width_p    = 40,
   parameter int data_width_p     = 64,
   parameter int num_dev_p        = 5,
   parameter int timeout_cycles_p = 1024
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic                              cmd_v_i,
   output logic                              cmd_ready_o,
   input  logic [paddr_width_p-1:0]          cmd_addr_i,
   input  logic                              cmd_wr_i,
   input  logic [1:0]                        cmd_size_i,
   input  logic [data_width_p-1:0]           cmd_data_i,
   output logic                              resp_v_o,
   input  logic                              resp_yumi_i,
   output logic [data_width_p-1:0]           resp_data_o,
   output logic                              resp_err_o,
   output logic [num_dev_p-1:0]              dev_cmd_v_o,
   input  logic [num_dev_p-1:0]              dev_cmd_ready_i,
   output logic [paddr_width_p-1:0]          dev_cmd_addr_o,
   output logic                              dev_cmd_wr_o,
   output logic [1:0]                        dev_cmd_size_o,
   output logic [data_width_p-1:0]           dev_cmd_data_o,
   input  logic [num_dev_p-1:0]              dev_resp_v_i,
   input  logic [num_dev_p*data_width_p-1:0] dev_resp_data_i,
   output logic [num_dev_p-1:0]              dev_resp_yumi_o,
   output logic                              stray_resp_o,
   output logic [1:0]                        state_o
);

   // Handshakes: a transfer happens on any cycle where valid & ready (or valid & yumi) are high.
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEND = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   localparam int tcnt_width_lp = (timeout_cycles_p > 0) ? $clog2(timeout_cycles_p + 1) : 1;
   localparam logic [tcnt_width_lp-1:0] tcnt_last_lp =
      (timeout_cycles_p > 0) ? tcnt_width_lp'(timeout_cycles_p - 1) : '0;
   localparam logic [tcnt_width_lp-1:0] tcnt_max_lp = tcnt_width_lp'(timeout_cycles_p);

   logic [1:0]               state_q, state_d;
   logic [paddr_width_p-1:0] addr_q, addr_d;
   logic                     wr_q, wr_d;
   logic [1:0]               size_q, size_d;
   logic [data_width_p-1:0]  data_q, data_d;
   logic [3:0]               sel_q, sel_d;
   logic [data_width_p-1:0]  resp_data_q, resp_data_d;
   logic                     resp_err_q, resp_err_d;
   logic [tcnt_width_lp-1:0] tcnt_q, tcnt_d;

   logic                     mapped;
   logic [31:0]              dev_id_ext;
   logic                     sel_ready, sel_resp_v, expire;
   logic [data_width_p-1:0]  sel_data;
   logic [tcnt_width_lp-1:0] tcnt_inc;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wr_d        = wr_q;
      size_d      = size_q;
      data_d      = data_q;
      sel_d       = sel_q;
      resp_data_d = resp_data_q;
      resp_err_d  = resp_err_q;
      tcnt_d      = tcnt_q;

      cmd_ready_o     = (state_q == IDLE) && !reset_i;
      dev_cmd_v_o     = '0;
      dev_resp_yumi_o = '0;
      stray_resp_o    = 1'b0;

      dev_id_ext = {28'd0, cmd_addr_i[23:20]};
      mapped     = (cmd_addr_i[paddr_width_p-1:24] == '0) && (dev_id_ext < 32'(num_dev_p));

      sel_ready  = 1'b0;
      sel_resp_v = 1'b0;
      sel_data   = '0;
      for (int i = 0; i < num_dev_p; i++) begin
         if (sel_q == 4'(i)) begin
            sel_ready  = dev_cmd_ready_i[i];
            sel_resp_v = dev_resp_v_i[i];
            sel_data   = dev_resp_data_i[i*data_width_p +: data_width_p];
         end
      end

      // Counter saturates, so an expiry lost to a same-cycle handshake still fires in WAIT.
      tcnt_inc = (tcnt_q == tcnt_max_lp) ? tcnt_q : tcnt_q + 1'b1;
      expire   = (timeout_cycles_p != 0) && (tcnt_q >= tcnt_last_lp);

      case (state_q)
         IDLE: begin
            if (cmd_v_i) begin
               addr_d = cmd_addr_i;
               wr_d   = cmd_wr_i;
               size_d = cmd_size_i;
               data_d = cmd_data_i;
               if (mapped) begin
                  state_d = SEND;
                  sel_d   = cmd_addr_i[23:20];
                  tcnt_d  = '0;
               end else begin
                  state_d     = RESP;
                  resp_err_d  = 1'b1;
                  resp_data_d = '0;
               end
            end
         end
         SEND: begin
            for (int i = 0; i < num_dev_p; i++) begin
               dev_cmd_v_o[i] = (sel_q == 4'(i));
            end
            tcnt_d = tcnt_inc;
            if (sel_ready) begin
               state_d = WAIT;
            end else if (expire) begin
               state_d     = RESP;
               resp_err_d  = 1'b1;
               resp_data_d = '0;
            end
         end
         WAIT: begin
            tcnt_d = tcnt_inc;
            if (sel_resp_v) begin
               state_d     = RESP;
               resp_err_d  = 1'b0;
               resp_data_d = sel_data;
            end else if (expire) begin
               state_d     = RESP;
               resp_err_d  = 1'b1;
               resp_data_d = '0;
            end
         end
         RESP: begin
            if (resp_yumi_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Everything except the selected device's response in WAIT is drained as stray.
      for (int i = 0; i < num_dev_p; i++) begin
         if (dev_resp_v_i[i] && !reset_i) begin
            dev_resp_yumi_o[i] = 1'b1;
            if (!((state_q == WAIT) && (sel_q == 4'(i)))) begin
               stray_resp_o = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wr_q        <= 1'b0;
         size_q      <= '0;
         data_q      <= '0;
         sel_q       <= '0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
         tcnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wr_q        <= wr_d;
         size_q      <= size_d;
         data_q      <= data_d;
         sel_q       <= sel_d;
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
         tcnt_q      <= tcnt_d;
      end
   end

   assign resp_v_o       = (state_q == RESP);
   assign resp_data_o    = resp_data_q;
   assign resp_err_o     = resp_err_q;
   assign dev_cmd_addr_o = addr_q;
   assign dev_cmd_wr_o   = wr_q;
   assign dev_cmd_size_o = size_q;
   assign dev_cmd_data_o = data_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_bp_io_dev_router.sv
// Directed bench for bp_io_dev_router: one task per scenario, hand-computed cycle-exact expectations.
module tb_bp_io_dev_router;

   localparam int PW = 40;
   localparam int DW = 64;
   localparam int ND = 5;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd2;

   logic            clk = 1'b0;
   logic            reset_i;
   logic            cmd_v_i;
   logic            cmd_ready_o;
   logic [PW-1:0]   cmd_addr_i;
   logic            cmd_wr_i;
   logic [1:0]      cmd_size_i;
   logic [DW-1:0]   cmd_data_i;
   logic            resp_v_o;
   logic            resp_yumi_i;
   logic [DW-1:0]   resp_data_o;
   logic            resp_err_o;
   logic [ND-1:0]   dev_cmd_v_o;
   logic [ND-1:0]   dev_cmd_ready_i;
   logic [PW-1:0]   dev_cmd_addr_o;
   logic            dev_cmd_wr_o;
   logic [1:0]      dev_cmd_size_o;
   logic [DW-1:0]   dev_cmd_data_o;
   logic [ND-1:0]   dev_resp_v_i;
   logic [ND*DW-1:0] dev_resp_data_i;
   logic [ND-1:0]   dev_resp_yumi_o;
   logic            stray_resp_o;
   logic [1:0]      state_o;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   bp_io_dev_router #(
      .paddr_width_p(PW), .data_width_p(DW), .num_dev_p(ND), .timeout_cycles_p(16)
   ) dut (
      .clk_i(clk), .reset_i(reset_i),
      .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
      .cmd_wr_i(cmd_wr_i), .cmd_size_i(cmd_size_i), .cmd_data_i(cmd_data_i),
      .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i), .resp_data_o(resp_data_o),
      .resp_err_o(resp_err_o), .dev_cmd_v_o(dev_cmd_v_o), .dev_cmd_ready_i(dev_cmd_ready_i),
      .dev_cmd_addr_o(dev_cmd_addr_o), .dev_cmd_wr_o(dev_cmd_wr_o),
      .dev_cmd_size_o(dev_cmd_size_o), .dev_cmd_data_o(dev_cmd_data_o),
      .dev_resp_v_i(dev_resp_v_i), .dev_resp_data_i(dev_resp_data_i),
      .dev_resp_yumi_o(dev_resp_yumi_o), .stray_resp_o(stray_resp_o), .state_o(state_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_i = 1'b1; cmd_v_i = 1'b0; cmd_addr_i = '0; cmd_wr_i = 1'b0; cmd_size_i = 2'd0;
      cmd_data_i = '0; resp_yumi_i = 1'b0; dev_cmd_ready_i = '0; dev_resp_v_i = '0;
      dev_resp_data_i = '0;
      repeat (2) tick();
      #1;
      total++;
      if (cmd_ready_o !== 1'b0) begin
         bad++; $display("FAIL reset_ready got=%b exp=0", cmd_ready_o);
      end
      total++;
      if ({resp_v_o, resp_err_o, dev_cmd_v_o, stray_resp_o, state_o} !== 10'd0) begin
         bad++; $display("FAIL reset_ctrl got=%b%b %b %b %b exp=all zero",
                         resp_v_o, resp_err_o, dev_cmd_v_o, stray_resp_o, state_o);
      end
      total++;
      if ({resp_data_o, dev_cmd_addr_o, dev_cmd_data_o, dev_cmd_wr_o, dev_cmd_size_o} !== '0) begin
         bad++; $display("FAIL reset_data got=%h %h %h exp=0", resp_data_o, dev_cmd_addr_o, dev_cmd_data_o);
      end
      reset_i = 1'b0;
      #1;
      total++;
      if (cmd_ready_o !== 1'b1) begin
         bad++; $display("FAIL post_reset_ready got=%b exp=1", cmd_ready_o);
      end
   endtask

   task automatic test_clint_load();
      tick();
      cmd_v_i = 1'b1; cmd_addr_i = 40'h00_0030_bff8; cmd_wr_i = 1'b0; cmd_size_i = 2'd3;
      #1;
      total++;
      if (cmd_ready_o !== 1'b1) begin
         bad++; $display("FAIL clint_accept got=%b exp=1", cmd_ready_o);
      end
      tick();
      cmd_v_i = 1'b0; dev_cmd_ready_i = 5'b01000;
      #1;
      total++;
      if (dev_cmd_v_o !== 5'b01000) begin
         bad++; $display("FAIL clint_cmd_v got=%b exp=01000", dev_cmd_v_o);
      end
      total++;
      if (dev_cmd_addr_o !== 40'h00_0030_bff8) begin
         bad++; $display("FAIL clint_cmd_addr got=%h exp=000030bff8", dev_cmd_addr_o);
      end
      tick();
      dev_cmd_ready_i = '0;
      #1;
      total++;
      if (state_o !== S_WAIT || dev_cmd_v_o !== 5'b0 || resp_v_o !== 1'b0) begin
         bad++; $display("FAIL clint_wait got=st%0d v%b r%b exp=st2 v00000 r0", state_o, dev_cmd_v_o, resp_v_o);
      end
      tick();
      dev_resp_v_i = 5'b01000; dev_resp_data_i[3*DW +: DW] = 64'h0000_0000_dead_beef;
      #1;
      total++;
      if (dev_resp_yumi_o !== 5'b01000 || stray_resp_o !== 1'b0 || resp_v_o !== 1'b0) begin
         bad++; $display("FAIL clint_yumi got=%b stray=%b rv=%b exp=01000 0 0", dev_resp_yumi_o, stray_resp_o, resp_v_o);
      end
      tick();
      dev_resp_v_i = '0;
      #1;
      total++;
      if (resp_v_o !== 1'b1 || resp_data_o !== 64'h0000_0000_dead_beef || resp_err_o !== 1'b0) begin
         bad++; $display("FAIL clint_resp got=v%b d%h e%b exp=v1 ddeadbeef e0", resp_v_o, resp_data_o, resp_err_o);
      end
      resp_yumi_i = 1'b1;
      tick();
      resp_yumi_i = 1'b0;
      #1;
      total++;
      if (resp_v_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
         bad++; $display("FAIL clint_done got=v%b rdy%b exp=v0 rdy1", resp_v_o, cmd_ready_o);
      end
   endtask

   task automatic test_cfg_store_backpressure();
      tick();
      cmd_v_i = 1'b1; cmd_addr_i = 40'h00_0020_0010; cmd_wr_i = 1'b1; cmd_size_i = 2'd3;
      cmd_data_i = 64'h1122_3344_5566_7788;
      #1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         cmd_v_i = 1'b0; cmd_data_i = '1; cmd_addr_i = '1;
         dev_cmd_ready_i = (c == 8) ? 5'b00100 : 5'b00000;
         #1;
         total++;
         if (dev_cmd_v_o !== 5'b00100 || dev_cmd_addr_o !== 40'h00_0020_0010 ||
             dev_cmd_data_o !== 64'h1122_3344_5566_7788 || dev_cmd_wr_o !== 1'b1) begin
            bad++; $display("FAIL cfg_hold c=%0d got=v%b a%h d%h w%b exp=v00100 a0000200010 d1122334455667788 w1",
                            c, dev_cmd_v_o, dev_cmd_addr_o, dev_cmd_data_o, dev_cmd_wr_o);
         end
      end
      tick();
      dev_cmd_ready_i = '0; dev_resp_v_i = 5'b00100; dev_resp_data_i[2*DW +: DW] = 64'h0000_0000_0000_cafe;
      #1;
      total++;
      if (dev_cmd_v_o !== 5'b0 || dev_resp_yumi_o !== 5'b00100 || stray_resp_o !== 1'b0) begin
         bad++; $display("FAIL cfg_wait got=v%b y%b s%b exp=v00000 y00100 s0", dev_cmd_v_o, dev_resp_yumi_o, stray_resp_o);
      end
      tick();
      dev_resp_v_i = '0;
      #1;
      total++;
      if (resp_v_o !== 1'b1 || resp_data_o !== 64'h0000_0000_0000_cafe || resp_err_o !== 1'b0) begin
         bad++; $display("FAIL cfg_resp got=v%b d%h e%b exp=v1 dcafe e0", resp_v_o, resp_data_o, resp_err_o);
      end
      resp_yumi_i = 1'b1;
      tick();
      resp_yumi_i = 1'b0; cmd_wr_i = 1'b0;
   endtask

   task automatic test_unmapped();
      logic [PW-1:0] addrs [2];
      addrs[0] = 40'h00_0050_0000;
      addrs[1] = 40'h01_0000_0000;
      for (int i = 0; i < 2; i++) begin
         tick();
         cmd_v_i = 1'b1; cmd_addr_i = addrs[i]; cmd_wr_i = 1'b0;
         #1;
         tick();
         cmd_v_i = 1'b0;
         #1;
         total++;
         if (dev_cmd_v_o !== 5'b0 || resp_v_o !== 1'b1 || resp_err_o !== 1'b1 || resp_data_o !== '0) begin
            bad++; $display("FAIL unmapped_%0d got=v%b rv%b e%b d%h exp=v00000 rv1 e1 d0",
                            i, dev_cmd_v_o, resp_v_o, resp_err_o, resp_data_o);
         end
         resp_yumi_i = 1'b1;
         tick();
         resp_yumi_i = 1'b0;
         #1;
      end
   endtask

   task automatic test_timeout();
      tick();
      cmd_v_i = 1'b1; cmd_addr_i = 40'h00_0010_0000;
      #1;
      tick();
      cmd_v_i = 1'b0; dev_cmd_ready_i = 5'b00010;
      #1;
      total++;
      if (dev_cmd_v_o !== 5'b00010) begin
         bad++; $display("FAIL host_cmd_v got=%b exp=00010", dev_cmd_v_o);
      end
      for (int c = 2; c <= 16; c++) begin
         tick();
         dev_cmd_ready_i = '0;
         #1;
         if (c == 16) begin
            total++;
            if (resp_v_o !== 1'b0) begin
               bad++; $display("FAIL timeout_early got=%b exp=0", resp_v_o);
            end
         end
      end
      tick();
      #1;
      total++;
      if (resp_v_o !== 1'b1 || resp_err_o !== 1'b1 || resp_data_o !== '0) begin
         bad++; $display("FAIL timeout_resp got=v%b e%b d%h exp=v1 e1 d0", resp_v_o, resp_err_o, resp_data_o);
      end
      resp_yumi_i = 1'b1;
      tick();
      resp_yumi_i = 1'b0; dev_resp_v_i = 5'b00010; dev_resp_data_i[1*DW +: DW] = 64'h77;
      #1;
      total++;
      if (stray_resp_o !== 1'b1 || dev_resp_yumi_o !== 5'b00010 || resp_v_o !== 1'b0) begin
         bad++; $display("FAIL late_stray got=s%b y%b rv%b exp=s1 y00010 rv0", stray_resp_o, dev_resp_yumi_o, resp_v_o);
      end
      tick();
      dev_resp_v_i = '0;
      #1;
      total++;
      if (resp_v_o !== 1'b0 || state_o !== S_IDLE || stray_resp_o !== 1'b0) begin
         bad++; $display("FAIL late_idle got=rv%b st%0d s%b exp=rv0 st0 s0", resp_v_o, state_o, stray_resp_o);
      end
   endtask

   task automatic test_resp_hold();
      tick();
      cmd_v_i = 1'b1; cmd_addr_i = 40'h00_0000_1000;
      #1;
      tick();
      cmd_v_i = 1'b0; dev_cmd_ready_i = 5'b00001;
      #1;
      tick();
      dev_cmd_ready_i = '0; dev_resp_v_i = 5'b00001; dev_resp_data_i[0 +: DW] = 64'ha5a5_0000_1234_5678;
      #1;
      tick();
      dev_resp_v_i = '0; cmd_v_i = 1'b1; cmd_addr_i = 40'h00_0090_0000;
      #1;
      for (int h = 0; h < 11; h++) begin
         total++;
         if ({resp_v_o, resp_err_o, resp_data_o, cmd_ready_o} !== {1'b1, 1'b0, 64'ha5a5_0000_1234_5678, 1'b0}) begin
            bad++; $display("FAIL hold_%0d got=v%b e%b d%h rdy%b exp=v1 e0 da5a5000012345678 rdy0",
                            h, resp_v_o, resp_err_o, resp_data_o, cmd_ready_o);
         end
         tick();
         #1;
      end
      resp_yumi_i = 1'b1;
      #1;
      total++;
      if (cmd_ready_o !== 1'b0) begin
         bad++; $display("FAIL yumi_cycle_ready got=%b exp=0", cmd_ready_o);
      end
      tick();
      resp_yumi_i = 1'b0;
      #1;
      total++;
      if (cmd_ready_o !== 1'b1 || resp_v_o !== 1'b0) begin
         bad++; $display("FAIL after_yumi got=rdy%b rv%b exp=rdy1 rv0", cmd_ready_o, resp_v_o);
      end
      tick();
      cmd_v_i = 1'b0;
      #1;
      total++;
      if (resp_v_o !== 1'b1 || resp_err_o !== 1'b1) begin
         bad++; $display("FAIL next_accept got=rv%b e%b exp=rv1 e1", resp_v_o, resp_err_o);
      end
      resp_yumi_i = 1'b1;
      tick();
      resp_yumi_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      tick();
      cmd_v_i = 1'b1; cmd_addr_i = 40'h00_0040_0040;
      #1;
      tick();
      cmd_v_i = 1'b0; dev_cmd_ready_i = 5'b10000;
      #1;
      tick();
      dev_cmd_ready_i = '0;
      #1;
      total++;
      if (state_o !== S_WAIT) begin
         bad++; $display("FAIL mid_wait got=%0d exp=2", state_o);
      end
      tick();
      reset_i = 1'b1;
      #1;
      tick();
      reset_i = 1'b0;
      #1;
      total++;
      if (state_o !== S_IDLE || dev_cmd_v_o !== 5'b0 || resp_v_o !== 1'b0 || resp_err_o !== 1'b0 ||
          dev_cmd_addr_o !== '0 || dev_cmd_data_o !== '0 || stray_resp_o !== 1'b0) begin
         bad++; $display("FAIL mid_reset got=st%0d v%b rv%b e%b a%h d%h s%b exp=all zero",
                         state_o, dev_cmd_v_o, resp_v_o, resp_err_o, dev_cmd_addr_o, dev_cmd_data_o, stray_resp_o);
      end
      dev_resp_v_i = 5'b10000; dev_resp_data_i[4*DW +: DW] = 64'h99;
      #1;
      total++;
      if (stray_resp_o !== 1'b1 || dev_resp_yumi_o !== 5'b10000) begin
         bad++; $display("FAIL mid_stray got=s%b y%b exp=s1 y10000", stray_resp_o, dev_resp_yumi_o);
      end
      tick();
      dev_resp_v_i = '0;
      #1;
      total++;
      if (resp_v_o !== 1'b0) begin
         bad++; $display("FAIL mid_no_resp got=%b exp=0", resp_v_o);
      end
   endtask

   task automatic test_back_to_back();
      dev_cmd_ready_i = 5'b11111;
      cmd_addr_i = 40'h00_0040_0040; cmd_wr_i = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick();
         cmd_v_i = 1'b1;
         dev_resp_v_i = (c % 4 == 2) ? 5'b10000 : 5'b00000;
         dev_resp_data_i[4*DW +: DW] = 64'h100 + 64'(c);
         resp_yumi_i = (c % 4 == 3);
         #1;
         if (c % 4 == 0) begin
            total++;
            if (cmd_ready_o !== 1'b1) begin
               bad++; $display("FAIL b2b_ready c=%0d got=%b exp=1", c, cmd_ready_o);
            end
         end
         if (c % 4 == 2) begin
            total++;
            if (dev_resp_yumi_o !== 5'b10000 || stray_resp_o !== 1'b0) begin
               bad++; $display("FAIL b2b_yumi c=%0d got=y%b s%b exp=y10000 s0", c, dev_resp_yumi_o, stray_resp_o);
            end
         end
         if (c % 4 == 3) begin
            total++;
            if (resp_v_o !== 1'b1 || resp_err_o !== 1'b0 || resp_data_o !== 64'h100 + 64'(c - 1)) begin
               bad++; $display("FAIL b2b_resp c=%0d got=v%b e%b d%h exp=v1 e0 d%h",
                               c, resp_v_o, resp_err_o, resp_data_o, 64'h100 + 64'(c - 1));
            end
         end
      end
      tick();
      cmd_v_i = 1'b0; resp_yumi_i = 1'b0; dev_resp_v_i = '0; dev_cmd_ready_i = '0;
      #1;
   endtask

   initial begin
      test_reset();
      test_clint_load();
      test_cfg_store_backpressure();
      test_unmapped();
      test_timeout();
      test_resp_hold();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
